// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// ---------------
// Synchronous FIFO controller that owns both ports of an external dual-port
// RAM (registered read, one cycle of read latency, no reset on storage) and
// exposes valid/ready streams on the input and output sides. Read addresses
// are issued ahead of demand. The RAM read latency is absorbed by a 2-entry
// output register buffer, so the output can sustain one word per cycle.
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      upstream word present
//   in_data       upstream word
//   in_ready      controller accepts in_data this cycle (not full)
//   out_valid     out_data holds a valid word
//   out_data      head (oldest) word
//   out_ready     downstream consumes the head word this cycle
//   level         words held: RAM + in-flight read + output buffer
//   ram_wr_en     RAM write enable
//   ram_addr_wr   RAM write address
//   ram_data_in   RAM write data
//   ram_addr_rd   RAM read address
//   ram_data_out  RAM read data, valid one cycle after the address

module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr_wr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_rd,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic [PW-1:0] ram_occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          rd_issue;
    logic [2:0]    buf_after;
    logic [1:0]    wr_slot;

    always_comb begin
        ram_occ = wr_ptr_q - rd_ptr_q;
        // occupancy never exceeds 2**ADDR_WIDTH, so its MSB alone marks full
        full    = ram_occ[ADDR_WIDTH];
        empty   = (ram_occ == '0);

        in_ready = !full;
        push     = in_valid && in_ready;
        pop      = (buf_cnt_q != 2'd0) && out_ready;

        // buffer occupancy after this edge's capture and pop; a read may only
        // be issued if its data will still find a free slot when it lands
        buf_after = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_issue  = !empty && (buf_after < 3'd2);

        wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, rd_issue};
        inflight_d = rd_issue;
        buf_cnt_d  = buf_after[1:0];

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        // captured word lands behind whatever survives this cycle's pop
        wr_slot = buf_cnt_q - {1'b0, pop};
        if (inflight_q) begin
            if (wr_slot == 2'd0) begin
                buf0_d = ram_data_out;
            end else begin
                buf1_d = ram_data_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    // write strobe must stay quiet while reset is held, even with in_valid high
    assign ram_wr_en   = push && rst_n;
    assign ram_addr_wr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_data_in = in_data;
    assign ram_addr_rd = rd_ptr_q[ADDR_WIDTH-1:0];

    assign out_valid = (buf_cnt_q != 2'd0);
    assign out_data  = buf0_q;
    assign level     = {1'b0, ram_occ} + {{(ADDR_WIDTH+1){1'b0}}, inflight_q}
                     + {{ADDR_WIDTH{1'b0}}, buf_cnt_q};

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int CAP = (1 << AW) + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW+1:0] level;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr_wr;
    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] ram_addr_rd;
    logic [DW-1:0] ram_data_out;

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .level        (level),
        .ram_wr_en    (ram_wr_en),
        .ram_addr_wr  (ram_addr_wr),
        .ram_data_in  (ram_data_in),
        .ram_addr_rd  (ram_addr_rd),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    // behavioural dual-port RAM: write commits at the edge, registered read
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr_wr] <= ram_data_in;
        ram_data_out <= mem[ram_addr_rd];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int pushes   = 0;
    int pops     = 0;
    logic [DW-1:0] expq [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: samples settled values at the falling edge, ahead of the rising
    // edge where the handshakes take effect
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", int'(level), expq.size());
            if (expq.size() == CAP) chk("in_ready_at_full", int'(in_ready), 0);
            chk("wr_en", int'(ram_wr_en), int'(in_valid && in_ready));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), int'(expq.pop_front()));
                end
                pops++;
            end
            if (in_valid && in_ready) begin
                if (expq.size() >= CAP) chk("overflow", expq.size(), CAP - 1);
                expq.push_back(in_data);
                pushes++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while (expq.size() != 0 && k < max_cycles) begin
            step();
            k++;
        end
        chk("drain_timeout", expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int rej;
        int p0;
        int q0;

        // reset state, write strobe suppressed while reset is held
        in_valid = 1'b1;
        #3;
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_wr_en", int'(ram_wr_en), 0);
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", int'(in_ready), 1);
        chk("rel_out_valid", int'(out_valid), 0);

        // single word latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("lat_e0_valid", int'(out_valid), 0);
        step();
        chk("lat_e1_valid", int'(out_valid), 0);
        step();
        chk("lat_e2_valid", int'(out_valid), 1);
        chk("lat_e2_data", int'(out_data), 8'hA5);
        step();
        chk("lat_level_back", int'(level), 0);

        // fill to capacity with the output stalled
        out_ready = 1'b0;
        p0 = pushes;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            step();
        end
        chk("fill_accepted", pushes - p0, CAP);
        chk("fill_level", int'(level), CAP);
        chk("fill_in_ready", int'(in_ready), 0);

        // full boundary: pop and push in the same cycle, push is refused
        in_data   = 8'hEE;
        out_ready = 1'b1;
        chk("full_pre_in_ready", int'(in_ready), 0);
        step();
        chk("full_post_in_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        gaps = 0;
        for (int k = 0; k < 256; k++) begin
            if (!out_valid) gaps++;
            step();
        end
        chk("fill_drain_gaps", gaps, 0);
        wait_drain(20);

        // streaming at one word per cycle
        step();
        p0 = pops;
        out_ready = 1'b1;
        gaps = 0;
        rej  = 0;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            if (!in_ready) rej++;
            step();
            if (i >= 2 && !out_valid) gaps++;
        end
        in_valid = 1'b0;
        chk("stream_rejects", rej, 0);
        chk("stream_gaps", gaps, 0);
        wait_drain(10);
        chk("stream_pops", pops - p0, 1000);

        // random traffic with backpressure, biased so the FIFO reaches full
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = $urandom_range(0, 1) != 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain(400);

        // reset mid-stream with five words held and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'h10 + i);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pre_reset_level", int'(level), 5);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_wr_en", int'(ram_wr_en), 0);
        expq.delete();
        step(); step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        p0 = pops;
        q0 = pushes;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        step();
        in_valid = 1'b0;
        wait_drain(10);
        step(); step(); step(); step();
        chk("post_rst_pushes", pushes - q0, 1);
        chk("post_rst_pops", pops - p0, 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_level", int'(level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
